spike_event_encoder: RTL

SPIKE_EVENT_ENCODER -- requirements
Module: spike_event_encoder

---
 rtl/spike_event_encoder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/spike_event_encoder.sv
// Spike event encoder: timestamps spikes from a LIF neuron, attaches the
// inter-spike interval and membrane potential, queues the events in a small
// first-word-fall-through FIFO, and reports a windowed spike rate.
//
// Event handshake: ev_valid is high whenever the FIFO holds an event and
// ev_ts/ev_isi/ev_pot present the oldest one; a transfer (pop) happens on a
// rising edge where ev_valid and ev_ready are both high; while ev_valid is high
// and ev_ready is low the presented event does not change.
module spike_event_encoder #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            spike_in,
    input  logic [7:0]      state_in,
    input  logic [7:0]      window_len,
    input  logic            ev_ready,
    output logic            ev_valid,
    output logic [TS_W-1:0] ev_ts,
    output logic [TS_W-1:0] ev_isi,
    output logic [7:0]      ev_pot,
    output logic [7:0]      rate,
    output logic            rate_valid,
    output logic            overflow,
    output logic [7:0]      drop_cnt,
    input  logic            clr_ovf
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [TS_W-1:0] isi;
        logic [7:0]      pot;
    } event_t;

    // Timestamp / interval state
    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] isi;
    logic            seen;

    // FIFO state; pointers carry one extra wrap bit to tell full from empty
    event_t          mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            empty;
    logic            full;
    logic            accept;
    logic            pop;
    logic            push;
    logic            drop;
    event_t          head;

    // Rate window state
    logic            win_active;
    logic [7:0]      win_cnt;
    logic [7:0]      win_len_q;
    logic [7:0]      spk_cnt;
    logic [7:0]      len_eff;
    logic [7:0]      cnt_eff;
    logic [7:0]      spk_eff;
    logic [7:0]      spk_next;
    logic            win_run;
    logic            win_end;

    // Handshake and FIFO occupancy decode
    always_comb begin
        empty  = (wr_ptr == rd_ptr);
        full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        accept = en && spike_in;
        pop    = !empty && ev_ready;
        push   = accept && (!full || pop);
        drop   = accept && full && !pop;
        head   = mem[rd_ptr[AW-1:0]];
    end

    assign ev_valid = !empty;
    assign ev_ts    = head.ts;
    assign ev_isi   = head.isi;
    assign ev_pot   = head.pot;

    // Free-running timestamp and saturating inter-spike interval, frozen by en=0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts   <= '0;
            isi  <= '0;
            seen <= 1'b0;
        end else if (en) begin
            ts <= ts + 1'b1;
            if (spike_in) begin
                isi  <= {{(TS_W-1){1'b0}}, 1'b1};
                seen <= 1'b1;
            end else if (seen && (isi != {TS_W{1'b1}})) begin
                isi <= isi + 1'b1;
            end
        end
    end

    // Event storage; contents need no reset because pointers gate visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{ts: ts, isi: isi, pot: state_in};
        end
    end

    // FIFO pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Sticky overflow and saturating drop counter; a drop beats a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf)                drop_cnt <= 8'd1;
            else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    // Window bookkeeping: an idle window starts on an enabled cycle with a
    // nonzero window_len, and that start cycle is window cycle 1
    always_comb begin
        len_eff  = win_active ? win_len_q : window_len;
        cnt_eff  = win_active ? win_cnt   : 8'd0;
        spk_eff  = win_active ? spk_cnt   : 8'd0;
        spk_next = (accept && (spk_eff != 8'hFF)) ? spk_eff + 8'd1 : spk_eff;
        win_run  = en && (len_eff != 8'd0);
        win_end  = win_run && ((cnt_eff + 8'd1) == len_eff);
    end

    // Window counters, rate register and one-cycle rate_valid pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_active <= 1'b0;
            win_cnt    <= '0;
            win_len_q  <= '0;
            spk_cnt    <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
        end else begin
            rate_valid <= 1'b0;
            if (win_run) begin
                if (win_end) begin
                    rate       <= spk_next;
                    rate_valid <= 1'b1;
                    win_active <= 1'b0;
                    win_cnt    <= '0;
                    spk_cnt    <= '0;
                end else begin
                    win_active <= 1'b1;
                    win_cnt    <= cnt_eff + 8'd1;
                    spk_cnt    <= spk_next;
                    win_len_q  <= len_eff;
                end
            end
        end
    end

endmodule
